// File: rtl/lane_tick_scheduler_pkg.sv
// Shared timing definitions for the scheduler and the lane movers.
package game_timing_pkg;

  localparam int unsigned NUM_LANES_DEFAULT = 4;
  localparam int unsigned LEVEL_W           = 2;
  localparam int unsigned LANE_TABLE_LEN    = 4;

  // Lane periods in base ticks at level 0; higher levels shift these right.
  localparam int unsigned LANE_BASE_PERIOD [LANE_TABLE_LEN] = '{32, 24, 16, 8};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_RELOAD = 2'd2
  } sched_state_t;

  // Period of a lane at a given level, never below one base tick.
  // Lanes beyond the table reuse the last entry.
  function automatic int unsigned lane_period(input int unsigned lane,
                                              input logic [LEVEL_W-1:0] level);
    logic [1:0]  idx;
    int unsigned p;
    idx = (lane < LANE_TABLE_LEN) ? lane[1:0] : 2'(LANE_TABLE_LEN - 1);
    p   = LANE_BASE_PERIOD[idx] >> level;
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/lane_tick_scheduler_if.sv
// Control and tick bundle between the top level and the tick scheduler.
interface lane_tick_scheduler_if
  import game_timing_pkg::*;
#(
  parameter int unsigned NUM_LANES = NUM_LANES_DEFAULT
) ();

  logic                 i_Pause;
  logic [LEVEL_W-1:0]   i_Level;
  logic                 i_Level_Load;
  logic                 o_Base_Tick;
  logic [NUM_LANES-1:0] o_Lane_Tick;
  logic                 o_Level_Ack;
  logic [LEVEL_W-1:0]   o_Active_Level;

  modport master (
    output i_Pause, i_Level, i_Level_Load,
    input  o_Base_Tick, o_Lane_Tick, o_Level_Ack, o_Active_Level
  );

  modport slave (
    input  i_Pause, i_Level, i_Level_Load,
    output o_Base_Tick, o_Lane_Tick, o_Level_Ack, o_Active_Level
  );

endinterface

// File: rtl/lane_tick_scheduler_tick_prescaler.sv
// Base-tick prescaler: counts enabled cycles and flags the wrap cycle.
// o_Tick is the wrap decision; the caller registers it.
module tick_prescaler #(
  parameter int unsigned BASE_DIV = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Enable,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int unsigned     W    = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [W-1:0]    LAST = W'(BASE_DIV - 1);

  logic [W-1:0] cnt;

  // Count 0..BASE_DIV-1 while enabled; hold otherwise; clear wins.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear) begin
      cnt <= '0;
    end else if (i_Enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Wrap happens on an enabled edge with the counter at its last value.
  always_comb begin
    o_Tick = i_Enable && (cnt == LAST);
  end

endmodule

// File: rtl/lane_tick_scheduler.sv
// Game-speed timing enables: base tick plus one periodic tick per lane,
// with pause and a level-load handshake.
module lane_tick_scheduler
  import game_timing_pkg::*;
#(
  parameter int unsigned BASE_DIV  = 250000,
  parameter int unsigned NUM_LANES = NUM_LANES_DEFAULT,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  lane_tick_scheduler_if.slave sched
);

  sched_state_t         state;
  logic [LEVEL_W-1:0]   level_req;
  logic [LEVEL_W-1:0]   active_level;
  logic                 level_ack;
  logic                 run_en;
  logic                 reload_clr;
  logic                 base_hit;
  logic                 base_tick_q;
  logic [NUM_LANES-1:0] lane_hit;
  logic [NUM_LANES-1:0] lane_tick_q;

  // Timing advances on every edge whose next state is RUN, so a pause seen on
  // the wrap edge holds the prescaler at its last value and the held tick is
  // taken on the first edge that samples the pause released.
  always_comb begin
    reload_clr = (state == ST_RELOAD);
    run_en     = !reload_clr && !sched.i_Pause && !sched.i_Level_Load;
  end

  // Mode control: level load beats pause; RELOAD is a single cycle that
  // commits the requested level and raises the ack.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state        <= ST_RUN;
      level_req    <= '0;
      active_level <= '0;
      level_ack    <= 1'b0;
    end else begin
      level_ack <= 1'b0;
      unique case (state)
        ST_RUN, ST_PAUSED: begin
          if (sched.i_Level_Load) begin
            state     <= ST_RELOAD;
            level_req <= sched.i_Level;
          end else if (sched.i_Pause) begin
            state <= ST_PAUSED;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RELOAD: begin
          active_level <= level_req;
          level_ack    <= 1'b1;
          state        <= sched.i_Pause ? ST_PAUSED : ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  tick_prescaler #(
    .BASE_DIV (BASE_DIV)
  ) u_prescaler (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Enable (run_en),
    .i_Clear  (reload_clr),
    .o_Tick   (base_hit)
  );

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;

    always_comb begin
      period = CNT_W'(lane_period(k, active_level));
    end

    assign lane_hit[k] = base_hit && (cnt == period - 1'b1);

    // Lane counter steps once per base-tick decision and wraps at its period.
    always_ff @(posedge i_Clk) begin
      if (i_Reset || reload_clr) begin
        cnt <= '0;
      end else if (base_hit) begin
        cnt <= (cnt == period - 1'b1) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Register all tick decisions so every enable is a clean one-cycle pulse.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      base_tick_q <= 1'b0;
      lane_tick_q <= '0;
    end else begin
      base_tick_q <= base_hit;
      lane_tick_q <= lane_hit;
    end
  end

  assign sched.o_Base_Tick    = base_tick_q;
  assign sched.o_Lane_Tick    = lane_tick_q;
  assign sched.o_Level_Ack    = level_ack;
  assign sched.o_Active_Level = active_level;

endmodule

// File: tb/tb_lane_tick_scheduler.sv
// Bench for lane_tick_scheduler with BASE_DIV=4: directed scenarios then
// random pause/load/reset traffic, all checked against a counting model.
module tb_lane_tick_scheduler;

  localparam int unsigned DIV   = 4;
  localparam int unsigned LANES = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lane_tick_scheduler_if #(.NUM_LANES(LANES)) sched_bus ();

  lane_tick_scheduler #(
    .BASE_DIV  (DIV),
    .NUM_LANES (LANES),
    .CNT_W     (8)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .sched   (sched_bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: total running cycles and base ticks since the last
  // clear; ticks follow from divisibility rather than from counters.
  int unsigned base_per [LANES] = '{32, 24, 16, 8};
  int          m_run_cnt;
  int          m_base_cnt;
  bit          m_reloading;
  int unsigned m_req;
  int unsigned m_level;
  bit          exp_base;
  logic [3:0]  exp_lane;
  bit          exp_ack;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int unsigned period_of(input int unsigned k, input int unsigned lvl);
    int unsigned p;
    p = base_per[k] >> lvl;
    return (p == 0) ? 1 : p;
  endfunction

  task automatic model_edge();
    exp_base = 1'b0;
    exp_lane = '0;
    exp_ack  = 1'b0;
    if (rst) begin
      m_run_cnt   = 0;
      m_base_cnt  = 0;
      m_reloading = 1'b0;
      m_req       = 0;
      m_level     = 0;
    end else if (m_reloading) begin
      m_level     = m_req;
      m_run_cnt   = 0;
      m_base_cnt  = 0;
      m_reloading = 1'b0;
      exp_ack     = 1'b1;
    end else if (sched_bus.i_Level_Load) begin
      m_reloading = 1'b1;
      m_req       = 32'(sched_bus.i_Level);
    end else if (!sched_bus.i_Pause) begin
      m_run_cnt++;
      if (m_run_cnt % DIV == 0) begin
        exp_base = 1'b1;
        m_base_cnt++;
        for (int unsigned k = 0; k < LANES; k++)
          if (m_base_cnt % period_of(k, m_level) == 0) exp_lane[k] = 1'b1;
      end
    end
  endtask

  // One clock: model the edge, then compare all outputs on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    if (rst) cyc = 0;
    else     cyc++;
    @(negedge clk);
    check_eq("base_tick", 32'(sched_bus.o_Base_Tick), 32'(exp_base));
    check_eq("lane_tick", 32'(sched_bus.o_Lane_Tick), 32'(exp_lane));
    check_eq("level_ack", 32'(sched_bus.o_Level_Ack), 32'(exp_ack));
    check_eq("active_level", 32'(sched_bus.o_Active_Level), m_level);
  endtask

  task automatic do_reset();
    rst                    = 1'b1;
    sched_bus.i_Pause      = 1'b0;
    sched_bus.i_Level_Load = 1'b0;
    step();
    rst = 1'b0;
  endtask

  int first3, first2, early, ticks, acks, first_base;

  initial begin
    rst                    = 1'b1;
    sched_bus.i_Pause      = 1'b0;
    sched_bus.i_Level      = '0;
    sched_bus.i_Level_Load = 1'b0;
    @(negedge clk);

    // Reset, level 0, free running.
    do_reset();
    check_eq("reset_outputs", 32'({sched_bus.o_Base_Tick, sched_bus.o_Lane_Tick,
                                   sched_bus.o_Level_Ack, sched_bus.o_Active_Level}), 32'd0);
    first3 = -1; first2 = -1; early = 0; first_base = -1;
    repeat (70) begin
      step();
      if (sched_bus.o_Base_Tick && first_base < 0) first_base = cyc;
      if (sched_bus.o_Lane_Tick[3] && first3 < 0) first3 = cyc;
      if (sched_bus.o_Lane_Tick[2] && first2 < 0) first2 = cyc;
      if (cyc < 64 && (sched_bus.o_Lane_Tick[1] || sched_bus.o_Lane_Tick[0])) early++;
    end
    check_eq("first_base", first_base, 4);
    check_eq("first_lane3", first3, 32);
    check_eq("first_lane2", first2, 64);
    check_eq("no_early_lane01", early, 0);

    // Level 3 load at cycle 10.
    do_reset();
    sched_bus.i_Level = 2'd3;
    while (cyc < 10) step();
    sched_bus.i_Level_Load = 1'b1;
    step();
    sched_bus.i_Level_Load = 1'b0;
    step();
    check_eq("ack_cycle12", 32'(sched_bus.o_Level_Ack), 32'd1);
    check_eq("level3", 32'(sched_bus.o_Active_Level), 32'd3);
    ticks = 0; first2 = -1;
    repeat (40) begin
      step();
      if (sched_bus.o_Base_Tick != sched_bus.o_Lane_Tick[3]) ticks++;
      if (sched_bus.o_Lane_Tick[2] && first2 < 0) first2 = cyc;
    end
    check_eq("lane3_every_base", ticks, 0);
    check_eq("lvl3_first_lane2", first2, 20);

    // Pause for 20 cycles starting on a wrap edge.
    do_reset();
    sched_bus.i_Level = 2'd0;
    while (cyc < 7) step();
    sched_bus.i_Pause = 1'b1;
    ticks = 0;
    repeat (20) begin
      step();
      if (sched_bus.o_Base_Tick || |sched_bus.o_Lane_Tick) ticks++;
    end
    sched_bus.i_Pause = 1'b0;
    first_base = -1;
    repeat (8) begin
      step();
      if (sched_bus.o_Base_Tick && first_base < 0) first_base = cyc;
    end
    check_eq("pause_no_ticks", ticks, 0);
    check_eq("pause_release_tick", first_base, 28);

    // Level load together with pause.
    do_reset();
    repeat (5) step();
    sched_bus.i_Level      = 2'd2;
    sched_bus.i_Level_Load = 1'b1;
    sched_bus.i_Pause      = 1'b1;
    step();
    sched_bus.i_Level_Load = 1'b0;
    ticks = 0; acks = 0;
    repeat (15) begin
      step();
      if (sched_bus.o_Base_Tick || |sched_bus.o_Lane_Tick) ticks++;
      if (sched_bus.o_Level_Ack) acks++;
    end
    check_eq("loadpause_ticks", ticks, 0);
    check_eq("loadpause_acks", acks, 1);
    check_eq("loadpause_level", 32'(sched_bus.o_Active_Level), 32'd2);
    sched_bus.i_Pause = 1'b0;
    repeat (12) step();

    // Reset while an ack is pending.
    do_reset();
    sched_bus.i_Level = 2'd1;
    while (cyc < 49) step();
    sched_bus.i_Level_Load = 1'b1;
    step();
    sched_bus.i_Level_Load = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_drops_ack", 32'(sched_bus.o_Level_Ack), 32'd0);
    first_base = -1; acks = 0;
    repeat (8) begin
      step();
      if (sched_bus.o_Base_Tick && first_base < 0) first_base = cyc;
      if (sched_bus.o_Level_Ack) acks++;
    end
    check_eq("rst_level0", 32'(sched_bus.o_Active_Level), 32'd0);
    check_eq("rst_first_base", first_base, 4);
    check_eq("rst_no_ack", acks, 0);

    // Level load on two consecutive cycles.
    do_reset();
    repeat (3) step();
    sched_bus.i_Level      = 2'd1;
    sched_bus.i_Level_Load = 1'b1;
    acks = 0;
    repeat (2) begin
      step();
      if (sched_bus.o_Level_Ack) acks++;
    end
    sched_bus.i_Level_Load = 1'b0;
    repeat (6) begin
      step();
      if (sched_bus.o_Level_Ack) acks++;
    end
    check_eq("double_load_acks", acks, 1);

    // Random pause / load / reset traffic.
    do_reset();
    repeat (1500) begin
      if ($urandom_range(0, 15) == 0) sched_bus.i_Pause = ~sched_bus.i_Pause;
      sched_bus.i_Level_Load = ($urandom_range(0, 39) == 0);
      sched_bus.i_Level      = 2'($urandom_range(0, 3));
      rst                    = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lane_tick_scheduler.md
# lane_tick_scheduler

Generates every game-speed timing enable for the Frogger core from the single system clock: a base tick and one periodic tick per traffic lane, with lane periods set by the current difficulty level. Sits between the top level and the lane/obstacle movers, which advance only when their enable is high. Supports pause and a level-load handshake. All outputs are single-cycle enables in the `i_Clk` domain; no derived clocks.

## Interface
- `BASE_DIV`, 250000: system-clock cycles per base tick; must be ≥ 2. The default gives 10 ms at 25 MHz.
- `NUM_LANES`, 4: number of lane tick outputs.
- `CNT_W`, 8: width of the per-lane base-tick counters.

- `i_Clk`  in  1  system clock; the single clock for the block.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Pause`  in  1  level-sensitive freeze of all timing.
- `i_Level`  in  2  requested difficulty level, 0–3.
- `i_Level_Load`  in  1  one-cycle request to adopt `i_Level`.
- `o_Base_Tick`  out  1  one-cycle pulse every `BASE_DIV` running cycles.
- `o_Lane_Tick`  out  `NUM_LANES`  per-lane one-cycle movement enable.
- `o_Level_Ack`  out  1  one-cycle pulse confirming a level load.
- `o_Active_Level`  out  2  level currently in force.

## Operation
- Lane period in base ticks is `max(1, LANE_BASE_PERIOD[k] >> o_Active_Level)`.
  - `LANE_BASE_PERIOD` = {32, 24, 16, 8} for lanes 0–3.
  - At level 3 the periods are {4, 3, 2, 1}.
- State machine states are RUN, PAUSED and RELOAD. Reset enters RUN.
  - RUN → PAUSED when `i_Pause`=1.
  - PAUSED → RUN when `i_Pause`=0.
  - RUN or PAUSED → RELOAD when `i_Level_Load`=1. Level load has priority over a pause transition in the same cycle.
  - RELOAD lasts one cycle. It exits to PAUSED if `i_Pause`=1, otherwise to RUN.
- Prescaler, running only in RUN:
  - Counts 0 … `BASE_DIV`−1, then wraps to 0.
  - The wrap sets `o_Base_Tick` high for the next cycle.
- Lane counter k, updated only on a base-tick decision:
  - When `counter_k == period_k−1`, the counter clears to 0 and `o_Lane_Tick[k]` pulses in the same cycle as that `o_Base_Tick`.
  - Otherwise the counter increments.
- RELOAD actions:
  - Latch `i_Level` into `o_Active_Level`.
  - Clear the prescaler and all lane counters.
  - Suppress all ticks.
  - Pulse `o_Level_Ack` in the cycle after RELOAD.
- PAUSED:
  - Prescaler and lane counters hold their values.
  - No ticks are emitted.
  - No tick is lost or duplicated across the pause.
- `i_Level_Load` arriving while in RELOAD is ignored.
- A level load with the same value as the active level still performs a full RELOAD and ack.

## Timing
- Reset values: all outputs 0, `o_Active_Level`=0, prescaler 0, lane counters 0, state RUN.
- Reset wins over all other inputs in the same cycle.
- Reset asserted mid-count:
  - All outputs are 0 from the cycle after the reset edge.
  - A pending ack is dropped.
- First `o_Base_Tick` is high in the cycle `BASE_DIV` clocks after the last reset edge.
- First `o_Lane_Tick[k]` coincides with the `period_k`-th `o_Base_Tick`.
- Ticks are registered: all outputs change only on `i_Clk` edges, with one cycle of latency from the internal decision.
- Pause arriving on the cycle the prescaler would wrap:
  - The pause wins, and the prescaler holds at `BASE_DIV`−1.
  - The tick appears one cycle after `i_Pause` falls.
- Level-load latency:
  - `i_Level_Load` at edge n gives RELOAD at n+1 and `o_Level_Ack` at n+2.
  - The next base tick follows `BASE_DIV` running cycles after RELOAD.
- Width rules:
  - The prescaler is `$clog2(BASE_DIV)` bits wide.
  - `LANE_BASE_PERIOD` values must fit in `CNT_W`.
  - The shift is unsigned, and a period of 0 is clamped to 1.

## Structure
- Shared package/include `game_timing_pkg` holds:
  - `NUM_LANES` default, `LEVEL_W`=2;
  - the `LANE_BASE_PERIOD` constant array;
  - the state encoding (RUN/PAUSED/RELOAD).
  The lane movers use the same package.
- Sub-module `tick_prescaler` (params `BASE_DIV`):
  - Inputs: `i_Clk`, `i_Reset`, `i_Enable`, `i_Clear`.
  - Output: `o_Tick`.
  - An enable-pulse generator that replaces any divided-clock use.
- Lane counters are a generate loop inside the top module.

## Test plan
All scenarios use `BASE_DIV`=4.
- Reset released at level 0, no pause → `o_Base_Tick` is high at cycles 4, 8, 12, …; `o_Lane_Tick[3]` first at cycle 32; `o_Lane_Tick[2]` first at cycle 64; no other lane ticks before then.
- `i_Level`=3 with `i_Level_Load` at cycle 10 → RELOAD at 11, `o_Level_Ack` at 12, `o_Active_Level`=3. Afterwards lane 3 ticks with every base tick and lane 2 ticks every 8 cycles.
- `i_Pause` high for 20 cycles starting on a prescaler wrap cycle → zero ticks while paused. The held tick appears 1 cycle after release, and subsequent spacing is unchanged.
- `i_Level_Load` (`i_Level`=2) asserted together with `i_Pause` → ack is produced, level becomes 2, the state ends in PAUSED, and no ticks occur until pause drops.
- `i_Reset` pulsed at cycle 50 while `o_Level_Ack` is pending → ack is suppressed. All outputs are 0, level is 0, and the first base tick comes 4 cycles after reset.
- `i_Level_Load` pulsed on two consecutive cycles → exactly one RELOAD and one ack.
